// File: rtl/instruction_fetch_pkg.sv
// Shared MIPS fetch-stage definitions: jump opcodes, default vectors,
// the RUN/ISR state encoding and the next-PC source labels.
package instruction_fetch_pkg;

    localparam logic [5:0]  OP_J   = 6'b000010;
    localparam logic [5:0]  OP_JAL = 6'b000011;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_INT_VECTOR = 32'h0000_0004;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0008;

    typedef enum logic {
        RUN = 1'b0,
        ISR = 1'b1
    } fetchState_e;

    typedef enum logic [2:0] {
        SRC_EXC,
        SRC_BRANCH,
        SRC_JREG,
        SRC_INT,
        SRC_HOLD,
        SRC_JUMP,
        SRC_SEQ
    } pcSrc_e;

    function automatic logic [31:0] alignPc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic isJump(input logic [5:0] opcode);
        return (opcode == OP_J) || (opcode == OP_JAL);
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_next_select.sv
// Combinational priority mux choosing the next PC and reporting which
// source won, so the fetch register stage can decide bubble/hold/capture.
module pc_next_select
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] INT_VECTOR = DEFAULT_INT_VECTOR,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic [31:0] pc,
    input  logic [31:0] pcPlus4,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        excReq,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        jumpReg,
    input  logic [31:0] jumpRegTarget,
    input  logic        irq,
    input  logic        inRun,
    output logic [31:0] nextPc,
    output pcSrc_e      pcSrc
);

    // Redirects from later stages override stall; interrupt entry and
    // the early jump only happen when the front end is free to advance.
    always_comb begin
        nextPc = pcPlus4;
        pcSrc  = SRC_SEQ;
        if (excReq) begin
            nextPc = alignPc(EXC_VECTOR);
            pcSrc  = SRC_EXC;
        end else if (branchTaken) begin
            nextPc = alignPc(branchTarget);
            pcSrc  = SRC_BRANCH;
        end else if (jumpReg) begin
            nextPc = alignPc(jumpRegTarget);
            pcSrc  = SRC_JREG;
        end else if (inRun && irq && !stall) begin
            nextPc = alignPc(INT_VECTOR);
            pcSrc  = SRC_INT;
        end else if (stall) begin
            nextPc = pc;
            pcSrc  = SRC_HOLD;
        end else if (isJump(instruction[31:26])) begin
            nextPc = {pcPlus4[31:28], instruction[25:0], 2'b00};
            pcSrc  = SRC_JUMP;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS instruction fetch stage: PC, IF/ID pipeline register, EPC and the
// RUN/ISR interrupt state, with next-PC selection in pc_next_select.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] INT_VECTOR = DEFAULT_INT_VECTOR,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegTarget,
    input  logic        IRQ,
    input  logic        IntReturn,
    input  logic        ExcReq,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic [31:0] EPC,
    output logic        IRQAck
);

    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] nextPc;
    pcSrc_e      pcSrc;
    fetchState_e state;
    fetchState_e stateNext;
    logic        loadBubble;

    assign pcPlus4 = pc + 32'd4;
    assign Address = pc;

    pc_next_select #(
        .INT_VECTOR (INT_VECTOR),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_pc_next_select (
        .pc            (pc),
        .pcPlus4       (pcPlus4),
        .instruction   (Instruction),
        .stall         (Stall),
        .excReq        (ExcReq),
        .branchTaken   (BranchTaken),
        .branchTarget  (BranchTarget),
        .jumpReg       (JumpReg),
        .jumpRegTarget (JumpRegTarget),
        .irq           (IRQ),
        .inRun         (state == RUN),
        .nextPc        (nextPc),
        .pcSrc         (pcSrc)
    );

    // Any redirect squashes the word just fetched; IntReturn only leaves
    // ISR when no entry into ISR is happening in the same cycle.
    always_comb begin
        stateNext  = state;
        loadBubble = Flush;
        case (pcSrc)
            SRC_EXC, SRC_INT: begin
                stateNext  = ISR;
                loadBubble = 1'b1;
            end
            SRC_BRANCH, SRC_JREG: begin
                loadBubble = 1'b1;
            end
            default: ;
        endcase
        if ((pcSrc != SRC_EXC) && (pcSrc != SRC_INT) && (state == ISR) && IntReturn)
            stateNext = RUN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc                <= RESET_PC;
            state             <= RUN;
            IF_ID_Instruction <= 32'd0;
            IF_ID_PCPlus4     <= 32'd0;
            IF_ID_Valid       <= 1'b0;
            EPC               <= 32'd0;
            IRQAck            <= 1'b0;
        end else begin
            pc     <= nextPc;
            state  <= stateNext;
            IRQAck <= (pcSrc == SRC_INT);
            if (pcSrc == SRC_INT)
                EPC <= pc;
            if (loadBubble) begin
                IF_ID_Instruction <= 32'd0;
                IF_ID_PCPlus4     <= 32'd0;
                IF_ID_Valid       <= 1'b0;
            end else if (pcSrc != SRC_HOLD) begin
                IF_ID_Instruction <= Instruction;
                IF_ID_PCPlus4     <= pcPlus4;
                IF_ID_Valid       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, a mid-stream reset
// sequence, then random traffic against a behavioural fetch model.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic        Stall, Flush, BranchTaken, JumpReg, IRQ, IntReturn, ExcReq;
    logic [31:0] BranchTarget, JumpRegTarget;
    logic [31:0] IF_ID_Instruction, IF_ID_PCPlus4, EPC;
    logic        IF_ID_Valid, IRQAck;

    logic [31:0] mem [64];
    int          total = 0;
    int          bad   = 0;

    typedef struct {
        logic        stall, flush, br;
        logic [31:0] brT;
        logic        jr;
        logic [31:0] jrT;
        logic        irq, iret, exc;
        logic [31:0] pc, instr, pc4;
        logic        valid;
        logic [31:0] epc;
        logic        ack;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state
    logic [31:0] mPc, mInstr, mPc4, mEpc;
    logic        mValid, mAck, mIsr;

    assign Instruction = mem[Address[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk               (clk),
        .reset             (reset),
        .Address           (Address),
        .Instruction       (Instruction),
        .Stall             (Stall),
        .Flush             (Flush),
        .BranchTaken       (BranchTaken),
        .BranchTarget      (BranchTarget),
        .JumpReg           (JumpReg),
        .JumpRegTarget     (JumpRegTarget),
        .IRQ               (IRQ),
        .IntReturn         (IntReturn),
        .ExcReq            (ExcReq),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PCPlus4     (IF_ID_PCPlus4),
        .IF_ID_Valid       (IF_ID_Valid),
        .EPC               (EPC),
        .IRQAck            (IRQAck)
    );

    function automatic vec_t mkVec(
        input logic stall, flush, br, input logic [31:0] brT,
        input logic jr, input logic [31:0] jrT, input logic irq, iret, exc,
        input logic [31:0] pc, instr, pc4, input logic valid,
        input logic [31:0] epc, input logic ack);
        vec_t v;
        v.stall = stall; v.flush = flush; v.br = br; v.brT = brT;
        v.jr = jr; v.jrT = jrT; v.irq = irq; v.iret = iret; v.exc = exc;
        v.pc = pc; v.instr = instr; v.pc4 = pc4; v.valid = valid;
        v.epc = epc; v.ack = ack;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [31:0] pc, instr, pc4,
                            input logic valid, input logic [31:0] epc, input logic ack);
        checkOutput({tag, " pc"},    Address, pc);
        checkOutput({tag, " instr"}, IF_ID_Instruction, instr);
        checkOutput({tag, " pc4"},   IF_ID_PCPlus4, pc4);
        checkOutput({tag, " valid"}, {31'd0, IF_ID_Valid}, {31'd0, valid});
        checkOutput({tag, " epc"},   EPC, epc);
        checkOutput({tag, " ack"},   {31'd0, IRQAck}, {31'd0, ack});
    endtask

    task automatic applyStimulus(input vec_t v);
        Stall = v.stall; Flush = v.flush;
        BranchTaken = v.br; BranchTarget = v.brT;
        JumpReg = v.jr; JumpRegTarget = v.jrT;
        IRQ = v.irq; IntReturn = v.iret; ExcReq = v.exc;
    endtask

    task automatic clearInputs();
        Stall = 0; Flush = 0; BranchTaken = 0; BranchTarget = 0;
        JumpReg = 0; JumpRegTarget = 0; IRQ = 0; IntReturn = 0; ExcReq = 0;
    endtask

    task automatic resetDut();
        clearInputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        mPc = 32'h0; mInstr = 0; mPc4 = 0; mValid = 0; mEpc = 0; mAck = 0; mIsr = 0;
    endtask

    task automatic bubble();
        mInstr = 32'd0; mPc4 = 32'd0; mValid = 1'b0;
    endtask

    // One clock of fetch behaviour, derived from the priority rules
    task automatic modelStep();
        logic [31:0] pc4, word;
        logic        oldIsr;
        pc4    = mPc + 32'd4;
        word   = mem[mPc[7:2]];
        oldIsr = mIsr;
        mAck   = 1'b0;
        if (ExcReq) begin
            mPc = 32'h8; mIsr = 1'b1; bubble();
        end else if (BranchTaken) begin
            mPc = BranchTarget & 32'hFFFF_FFFC; bubble();
            if (oldIsr && IntReturn) mIsr = 1'b0;
        end else if (JumpReg) begin
            mPc = JumpRegTarget & 32'hFFFF_FFFC; bubble();
            if (oldIsr && IntReturn) mIsr = 1'b0;
        end else if (!oldIsr && IRQ && !Stall) begin
            mEpc = mPc; mPc = 32'h4; mIsr = 1'b1; mAck = 1'b1; bubble();
        end else begin
            if (Stall) begin
                if (Flush) bubble();
            end else begin
                if (word[31:26] == 6'd2 || word[31:26] == 6'd3)
                    mPc = {pc4[31:28], word[25:0], 2'b00};
                else
                    mPc = pc4;
                if (Flush) bubble();
                else begin
                    mInstr = word; mPc4 = pc4; mValid = 1'b1;
                end
            end
            if (oldIsr && IntReturn) mIsr = 1'b0;
        end
    endtask

    initial begin
        clearInputs();
        reset = 1'b0;
        foreach (mem[i]) mem[i] = 32'd0;
        mem[0]  = 32'h0800_000E;
        mem[15] = 32'h1234_5678;
        mem[16] = 32'hA5A5_A5A5;

        @(posedge clk);
        #1;
        checkAll("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        //            stall fl br brT          jr jrT          irq iret exc  pc           instr         pc4          v  epc    ack
        vecs.push_back(mkVec(0,0,0,0,           0,0,           0,0,0, 32'h38,       32'h0800000E, 32'h4,       1, 32'h0,  0));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           0,0,0, 32'h3C,       32'h0,        32'h3C,      1, 32'h0,  0));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           1,0,0, 32'h04,       32'h0,        32'h0,       0, 32'h3C, 1));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           1,0,0, 32'h08,       32'h0,        32'h08,      1, 32'h3C, 0));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           1,0,0, 32'h0C,       32'h0,        32'h0C,      1, 32'h3C, 0));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           1,1,0, 32'h10,       32'h0,        32'h10,      1, 32'h3C, 0));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           1,0,0, 32'h04,       32'h0,        32'h0,       0, 32'h10, 1));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           0,1,0, 32'h08,       32'h0,        32'h08,      1, 32'h10, 0));
        vecs.push_back(mkVec(0,0,1,32'h3C,      0,0,           0,0,0, 32'h3C,       32'h0,        32'h0,       0, 32'h10, 0));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           0,0,0, 32'h40,       32'h12345678, 32'h40,      1, 32'h10, 0));
        vecs.push_back(mkVec(1,0,0,0,           0,0,           0,0,0, 32'h40,       32'h12345678, 32'h40,      1, 32'h10, 0));
        vecs.push_back(mkVec(1,0,0,0,           0,0,           0,0,0, 32'h40,       32'h12345678, 32'h40,      1, 32'h10, 0));
        vecs.push_back(mkVec(1,0,0,0,           0,0,           0,0,0, 32'h40,       32'h12345678, 32'h40,      1, 32'h10, 0));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           0,0,0, 32'h44,       32'hA5A5A5A5, 32'h44,      1, 32'h10, 0));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           0,0,0, 32'h48,       32'h0,        32'h48,      1, 32'h10, 0));
        vecs.push_back(mkVec(1,0,1,32'h0E,      0,0,           0,0,0, 32'h0C,       32'h0,        32'h0,       0, 32'h10, 0));
        vecs.push_back(mkVec(0,1,0,0,           0,0,           0,0,0, 32'h10,       32'h0,        32'h0,       0, 32'h10, 0));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           0,0,0, 32'h14,       32'h0,        32'h14,      1, 32'h10, 0));
        vecs.push_back(mkVec(1,1,0,0,           0,0,           0,0,0, 32'h14,       32'h0,        32'h0,       0, 32'h10, 0));
        vecs.push_back(mkVec(0,0,0,0,           1,32'h33,      0,0,0, 32'h30,       32'h0,        32'h0,       0, 32'h10, 0));
        vecs.push_back(mkVec(1,0,0,0,           1,32'h50,      0,0,0, 32'h50,       32'h0,        32'h0,       0, 32'h10, 0));
        vecs.push_back(mkVec(0,0,1,32'h20,      0,0,           0,0,1, 32'h08,       32'h0,        32'h0,       0, 32'h10, 0));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           1,0,0, 32'h0C,       32'h0,        32'h0C,      1, 32'h10, 0));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           0,1,0, 32'h10,       32'h0,        32'h10,      1, 32'h10, 0));
        vecs.push_back(mkVec(1,0,0,0,           0,0,           1,0,0, 32'h10,       32'h0,        32'h10,      1, 32'h10, 0));
        vecs.push_back(mkVec(0,0,0,0,           1,32'h60,      1,0,0, 32'h60,       32'h0,        32'h0,       0, 32'h10, 0));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           1,0,0, 32'h04,       32'h0,        32'h0,       0, 32'h60, 1));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           0,0,1, 32'h08,       32'h0,        32'h0,       0, 32'h60, 0));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           0,1,0, 32'h0C,       32'h0,        32'h0C,      1, 32'h60, 0));
        vecs.push_back(mkVec(0,0,1,32'hFFFFFFFC,0,0,           0,0,0, 32'hFFFFFFFC, 32'h0,        32'h0,       0, 32'h60, 0));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           0,0,0, 32'h0,        32'h0,        32'h0,       1, 32'h60, 0));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           1,1,0, 32'h04,       32'h0,        32'h0,       0, 32'h0,  1));
        vecs.push_back(mkVec(0,0,0,0,           0,0,           0,0,0, 32'h08,       32'h0,        32'h08,      1, 32'h0,  0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkAll($sformatf("row%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].pc4,
                     vecs[i].valid, vecs[i].epc, vecs[i].ack);
        end

        // Asynchronous reset in the middle of a pending branch redirect
        clearInputs();
        BranchTaken  = 1'b1;
        BranchTarget = 32'h80;
        #3;
        reset = 1'b0;
        #1;
        checkAll("midreset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("midreset hold pc", Address, 32'h0);
        reset = 1'b1;
        clearInputs();
        @(posedge clk);
        #1;
        checkAll("postreset", 32'h38, 32'h0800000E, 32'h4, 1'b1, 32'h0, 1'b0);

        // Randomised traffic against the model
        foreach (mem[i]) begin
            mem[i] = $urandom;
            if ($urandom_range(0, 5) == 0)
                mem[i][31:26] = ($urandom_range(0, 1) == 0) ? 6'd2 : 6'd3;
        end
        resetDut();
        for (int c = 0; c < 600; c++) begin
            ExcReq        = ($urandom_range(0, 19) == 0);
            BranchTaken   = ($urandom_range(0, 11) == 0);
            BranchTarget  = $urandom;
            JumpReg       = ($urandom_range(0, 11) == 0);
            JumpRegTarget = $urandom;
            IRQ           = ($urandom_range(0, 3) == 0);
            IntReturn     = ($urandom_range(0, 5) == 0);
            Stall         = ($urandom_range(0, 4) == 0);
            Flush         = ($urandom_range(0, 7) == 0);
            modelStep();
            @(posedge clk);
            #1;
            checkAll($sformatf("rand%0d", c), mPc, mInstr, mPc4, mValid, mEpc, mAck);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
